// File: rtl/conv_layer_sched_if.sv
// Bus bundle between conv_layer_sched and its neighbours: the weight-ROM read port plus
// the conv_mix control/weight stream. master = the scheduler, slave = ROM/conv_mix side.
interface conv_layer_sched_if #(
    parameter int unsigned AW = 10
);
    logic          w_rd;
    logic [AW-1:0] w_addr;
    logic          w_data;
    logic          cm_weight_en;
    logic          cm_weight;
    logic          cm_state;
    logic          cm_start;
    logic          cm_ovalid;
    logic          cm_done;

    modport master (
        output w_rd, w_addr, cm_weight_en, cm_weight, cm_state, cm_start,
        input  w_data, cm_ovalid, cm_done
    );

    modport slave (
        input  w_rd, w_addr, cm_weight_en, cm_weight, cm_state, cm_start,
        output w_data, cm_ovalid, cm_done
    );
endinterface

// File: rtl/conv_layer_sched.sv
// Layer sequencer for conv_mix: per output channel, stream the binary kernel out of the
// weight ROM, hold start until conv_mix reports done, then advance channel/layer.
module conv_layer_sched #(
    parameter int unsigned KSIZE   = 5,
    parameter int unsigned L1_CH   = 6,
    parameter int unsigned L2_CH   = 16,
    parameter int unsigned AW      = 10,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic                   abort,
    conv_layer_sched_if.master     bus,
    output logic [4:0]             ch_idx,
    output logic                   busy,
    output logic                   finished,
    output logic                   err,
    output logic [9:0]             pool_cnt
);

    localparam int unsigned KK = KSIZE * KSIZE;
    localparam int unsigned KW = $clog2(KK);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWload  = 3'd1;
    localparam logic [2:0] StWdrain = 3'd2;
    localparam logic [2:0] StRun    = 3'd3;
    localparam logic [2:0] StGap    = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;
    localparam logic [2:0] StErr    = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [4:0]    ch_q, ch_d;
    logic          layer_q, layer_d;
    logic [11:0]   run_q, run_d;
    logic [9:0]    pool_q, pool_d;
    logic          wen_q;
    logic [AW-1:0] ch_glob;

    // Layer-2 kernels are stored after all layer-1 kernels in the ROM.
    always_comb begin
        ch_glob = AW'(ch_q);
        if (layer_q) begin
            ch_glob = ch_glob + AW'(L1_CH);
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ch_d    = ch_q;
        layer_d = layer_q;
        run_d   = run_q;
        pool_d  = pool_q;
        if (abort) begin
            state_d = StIdle;
            k_d     = '0;
            ch_d    = '0;
            layer_d = 1'b0;
            run_d   = '0;
            pool_d  = '0;
        end else begin
            case (state_q)
                StIdle, StErr: begin
                    if (go) begin
                        state_d = StWload;
                        k_d     = '0;
                        ch_d    = '0;
                        layer_d = 1'b0;
                    end
                end
                StWload: begin
                    k_d = k_q + 1'b1;
                    if (k_q == KW'(KK - 1)) begin
                        state_d = StWdrain;
                        k_d     = '0;
                    end
                end
                StWdrain: begin
                    state_d = StRun;
                    run_d   = '0;
                    pool_d  = '0;
                end
                StRun: begin
                    run_d = run_q + 1'b1;
                    if (bus.cm_ovalid && (pool_q != '1)) begin
                        pool_d = pool_q + 1'b1;
                    end
                    // done beats a timeout landing on the same cycle
                    if (bus.cm_done) begin
                        state_d = StGap;
                    end else if (run_q == 12'(TIMEOUT - 1)) begin
                        state_d = StErr;
                    end
                end
                StGap: begin
                    state_d = StWload;
                    if (!layer_q && (ch_q == 5'(L1_CH - 1))) begin
                        layer_d = 1'b1;
                        ch_d    = '0;
                    end else if (layer_q && (ch_q == 5'(L2_CH - 1))) begin
                        layer_d = 1'b0;
                        ch_d    = '0;
                        state_d = StDone;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            ch_q    <= '0;
            layer_q <= 1'b0;
            run_q   <= '0;
            pool_q  <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ch_q    <= ch_d;
            layer_q <= layer_d;
            run_q   <= run_d;
            pool_q  <= pool_d;
            wen_q   <= (state_q == StWload) && !abort;
        end
    end

    // ROM data lands one cycle after w_rd, lining up with the delayed enable.
    assign bus.w_rd         = (state_q == StWload);
    assign bus.w_addr       = (state_q == StWload) ? AW'(ch_glob * AW'(KK)) + AW'(k_q) : '0;
    assign bus.cm_weight_en = wen_q;
    assign bus.cm_weight    = wen_q & bus.w_data;
    assign bus.cm_state     = layer_q;
    assign bus.cm_start     = (state_q == StRun);

    assign ch_idx   = ch_q;
    assign busy     = (state_q != StIdle) && (state_q != StErr);
    assign finished = (state_q == StDone);
    assign err      = (state_q == StErr);
    assign pool_cnt = pool_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: random ROM contents and a stub conv_mix with random run
// lengths; observed bursts are compared against a channel-level expectation.
module tb_conv_layer_sched;

    localparam int unsigned KK      = 25;
    localparam int unsigned AW      = 10;
    localparam int unsigned NCH     = 22;
    localparam int unsigned TIMEOUT = 4095;

    logic       clk;
    logic       rst;
    logic       go;
    logic       abort;
    logic [4:0] ch_idx;
    logic       busy;
    logic       finished;
    logic       err;
    logic [9:0] pool_cnt;

    conv_layer_sched_if #(.AW(AW)) bus ();

    conv_layer_sched dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .abort    (abort),
        .bus      (bus),
        .ch_idx   (ch_idx),
        .busy     (busy),
        .finished (finished),
        .err      (err),
        .pool_cnt (pool_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic rom [0:1023];

    // Stub conv_mix + ROM
    int fixed_len = 0;
    bit hang      = 1'b0;
    bit ov_all    = 1'b0;
    bit spur      = 1'b0;
    int scnt      = 0;
    int cur_len   = 2;
    int req_q[$];

    always @(posedge clk) begin
        bus.w_data <= bus.w_rd ? rom[bus.w_addr] : 1'($urandom_range(0, 1));
        bus.cm_ovalid <= ov_all ? 1'b1 : ($urandom_range(0, 3) == 0);
        if (!bus.cm_start) begin
            scnt    <= 0;
            cur_len <= (fixed_len != 0) ? fixed_len : int'($urandom_range(2, 40));
            bus.cm_done <= spur && bus.w_rd && ($urandom_range(0, 1) == 1);
        end else begin
            if (scnt == 0) req_q.push_back(cur_len);
            scnt <= scnt + 1;
            bus.cm_done <= !hang && (scnt + 1 == cur_len - 1);
        end
    end

    // Monitor: groups activity into bursts
    logic [KK*AW-1:0] a_vec = '0;
    logic [KK-1:0]    b_vec = '0;
    int a_n = 0, b_n = 0, r_n = 0, r_ov = 0, g_n = 0, fin_n = 0;
    bit in_gap = 1'b0;
    int               a_len_q[$];
    logic [KK*AW-1:0] a_vec_q[$];
    int               b_len_q[$];
    logic [KK-1:0]    b_vec_q[$];
    int               st_q[$];
    int               ci_q[$];
    int               r_len_q[$];
    int               r_ov_q[$];
    int               r_pool_q[$];
    int               g_q[$];

    task automatic mon_step();
        if (bus.w_rd) begin
            if (a_n < KK) a_vec[a_n*AW +: AW] = bus.w_addr;
            a_n++;
        end else if (a_n != 0) begin
            a_len_q.push_back(a_n);
            a_vec_q.push_back(a_vec);
            a_n   = 0;
            a_vec = '0;
        end
        if (bus.cm_weight_en) begin
            if (b_n == 0) begin
                st_q.push_back(int'(bus.cm_state));
                ci_q.push_back(int'(ch_idx));
            end
            if (b_n < KK) b_vec[b_n] = bus.cm_weight;
            b_n++;
        end else if (b_n != 0) begin
            b_len_q.push_back(b_n);
            b_vec_q.push_back(b_vec);
            b_n   = 0;
            b_vec = '0;
        end
        if (bus.cm_start) begin
            r_n++;
            if (bus.cm_ovalid) r_ov++;
        end else if (r_n != 0) begin
            r_len_q.push_back(r_n);
            r_ov_q.push_back(r_ov);
            r_pool_q.push_back(int'(pool_cnt));
            r_n    = 0;
            r_ov   = 0;
            in_gap = 1'b1;
            g_n    = 1;
        end else if (in_gap) begin
            if (bus.w_rd) begin
                g_q.push_back(g_n);
                in_gap = 1'b0;
            end else if (!busy) begin
                in_gap = 1'b0;
            end else begin
                g_n++;
            end
        end
        if (finished) fin_n++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_step();
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_w(input string tag, input logic [KK*AW-1:0] got,
                         input logic [KK*AW-1:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    // One complete two-layer pass, checked channel by channel.
    task automatic run_pass(input int flen, input bit spurious, input bit go_busy);
        int a0, b0, r0, g0, q0, f0, na, nb, nr, ng;
        logic [KK*AW-1:0] ea;
        logic [KK-1:0]    eb;
        a0 = a_len_q.size(); b0 = b_len_q.size(); r0 = r_len_q.size();
        g0 = g_q.size();     q0 = req_q.size();   f0 = fin_n;
        fixed_len = flen;
        spur      = spurious;
        pulse_go();
        chk("go_first_wrd", bus.w_rd, 1);
        chk("go_first_addr", bus.w_addr, 0);
        chk("go_busy", busy, 1);
        for (int c = 0; c < 20000 && fin_n == f0; c++) begin
            go = go_busy && (c == 40 || c == 400);
            @(posedge clk); #1;
        end
        go   = 1'b0;
        spur = 1'b0;
        chk("pass_idle_busy", busy, 0);
        chk("pass_err", err, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("pass_finished_once", fin_n - f0, 1);
        na = a_len_q.size() - a0;
        nb = b_len_q.size() - b0;
        nr = r_len_q.size() - r0;
        ng = g_q.size() - g0;
        chk("addr_bursts", na, NCH);
        chk("weight_bursts", nb, NCH);
        chk("run_bursts", nr, NCH);
        chk("gap_count", ng, NCH - 1);
        for (int n = 0; n < NCH && n < na; n++) begin
            for (int k = 0; k < KK; k++) ea[k*AW +: AW] = AW'(n * KK + k);
            chk("addr_len", a_len_q[a0+n], KK);
            chk_w("addr_seq", a_vec_q[a0+n], ea);
        end
        for (int n = 0; n < NCH && n < nb; n++) begin
            for (int k = 0; k < KK; k++) eb[k] = rom[n*KK + k];
            chk("wen_len", b_len_q[b0+n], KK);
            chk("weight_bits", 32'(b_vec_q[b0+n]), 32'(eb));
            chk("cm_state", st_q[b0+n], (n >= 6) ? 1 : 0);
            chk("ch_idx", ci_q[b0+n], (n >= 6) ? n - 6 : n);
        end
        for (int n = 0; n < NCH && n < nr; n++) begin
            chk("run_len", r_len_q[r0+n], req_q[q0+n]);
            chk("pool_cnt", r_pool_q[r0+n], (r_ov_q[r0+n] > 1023) ? 1023 : r_ov_q[r0+n]);
        end
        for (int n = 0; n < ng; n++) chk("gap_len", g_q[g0+n], 1);
        if (na > 9) begin
            ea = a_vec_q[a0+9];
            chk("l2c3_first_addr", ea[AW-1:0], 225);
            chk("l2c3_last_addr", ea[(KK-1)*AW +: AW], 249);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wrd"}, bus.w_rd, 0);
        chk({tag, "_waddr"}, bus.w_addr, 0);
        chk({tag, "_wen"}, bus.cm_weight_en, 0);
        chk({tag, "_wbit"}, bus.cm_weight, 0);
        chk({tag, "_state"}, bus.cm_state, 0);
        chk({tag, "_start"}, bus.cm_start, 0);
        chk({tag, "_ch"}, ch_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fin"}, finished, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_pool"}, pool_cnt, 0);
    endtask

    initial begin
        int waited;
        int lastv;
        for (int i = 0; i < 1024; i++) rom[i] = 1'($urandom_range(0, 1));
        rst   = 1'b1;
        go    = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_pass(700, 1'b0, 1'b0);
        run_pass(0, 1'b1, 1'b1);

        // Timeout: stub never finishes, ovalid stuck high to saturate pool_cnt
        hang   = 1'b1;
        ov_all = 1'b1;
        pulse_go();
        waited = 0;
        while (!err && waited < 6000) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("timeout_err", err, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_start", bus.cm_start, 0);
        @(posedge clk); #1;
        lastv = (r_len_q.size() > 0) ? r_len_q[r_len_q.size()-1] : -1;
        chk("timeout_run_cycles", lastv, TIMEOUT);
        lastv = (r_pool_q.size() > 0) ? r_pool_q[r_pool_q.size()-1] : -1;
        chk("pool_saturate", lastv, 1023);
        chk("err_sticky", err, 1);
        hang   = 1'b0;
        ov_all = 1'b0;
        pulse_go();
        chk("restart_err_clr", err, 0);
        chk("restart_wrd", bus.w_rd, 1);
        chk("restart_addr", bus.w_addr, 0);
        chk("restart_state", bus.cm_state, 0);

        // abort mid-WLOAD
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk_all_zero("abort_wload");

        // abort mid-RUN, also checks go -> RUN latency
        fixed_len = 1000;
        pulse_go();
        waited = 0;
        while (!bus.cm_start && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("start_latency", waited, KK + 1);
        repeat (10) @(posedge clk);
        #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        chk("go_busy_ignored_start", bus.cm_start, 1);
        chk("go_busy_ignored_wrd", bus.w_rd, 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk_all_zero("abort_run");

        // rst mid-RUN
        pulse_go();
        waited = 0;
        while (!bus.cm_start && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_start", bus.cm_start, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("rst_run");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
